// File: rtl/adder_seq_pkg.sv
// ----------------------------------------------------------------------------
// adder_seq_pkg
//   Shared constants for the slice-serial adder/subtractor and its bench:
//   the controller state encoding and the helper that sizes the slice-index
//   counter.
// ----------------------------------------------------------------------------
package adder_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Width of a counter indexing n slices; a single slice still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// ----------------------------------------------------------------------------
// adder_slice
//   Purely combinational SLICE-bit ripple adder used once per cycle by
//   adder_seq.
//   Ports:
//     s     out SLICE  slice sum
//     c_out out 1      carry out of the slice MSB
//     c_msb out 1      carry into the slice MSB (used for signed overflow)
//     a, b  in  SLICE  slice operands (b already inverted for subtract)
//     c_in  in  1      carry into the slice LSB
// ----------------------------------------------------------------------------
module adder_slice #(
  parameter int SLICE = 8
) (
  output logic [SLICE-1:0] s,
  output logic             c_out,
  output logic             c_msb,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in
);

  logic [SLICE:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, c_in};
  assign s     = w_sum[SLICE-1:0];
  assign c_out = w_sum[SLICE];
  // The sum bit at the MSB is a ^ b ^ carry-in, so the carry-in falls out by
  // XOR-ing the operands back off; this also works when SLICE is 1.
  assign c_msb = w_sum[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];

endmodule

// File: rtl/adder_seq.sv
// ----------------------------------------------------------------------------
// adder_seq
//   Slice-serial WIDTH-bit adder/subtractor. Operands are captured on start
//   and added SLICE bits per cycle, LSB slice first, over N = WIDTH/SLICE
//   cycles with the carry chained through a register.
//   Ports:
//     clk    in  1      clock, rising edge
//     rst    in  1      synchronous active-high reset
//     start  in  1      request, sampled only while idle
//     a, b   in  WIDTH  operands, sampled with start
//     c_in   in  1      carry-in (add) / borrow-in (subtract)
//     sub    in  1      0 = add, 1 = subtract
//     busy   out 1      operation in progress
//     done   out 1      one-cycle pulse, results valid
//     s      out WIDTH  sum / difference (held until next completion)
//     c_out  out 1      carry out of MSB (subtract: 1 = no borrow)
//     v      out 1      signed overflow
// ----------------------------------------------------------------------------
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             v
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_c_out;
  logic             r_v;
  logic             r_done;

  logic [SLICE-1:0] w_ss;
  logic             w_sc;
  logic             w_smsb;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  // Operands are shifted right each cycle so the active slice is always in
  // the low bits; no variable part-selects are needed.
  adder_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .s     (w_ss),
    .c_out (w_sc),
    .c_msb (w_smsb),
    .a     (r_a[SLICE-1:0]),
    .b     (r_b[SLICE-1:0]),
    .c_in  (r_carry)
  );

  // Partial results enter at the top and shift down; after N slices the
  // first slice has reached bit 0. Works unchanged when N is 1.
  assign w_acc_next = (r_acc >> SLICE) | (WIDTH'(w_ss) << (WIDTH - SLICE));
  assign w_last     = (r_idx == LAST_IDX);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_IDLE;
      default:             w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_v     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start) begin
          // Subtract is a + ~b + ~c_in, so invert once at capture time.
          r_a     <= a;
          r_b     <= sub ? ~b : b;
          r_carry <= c_in ^ sub;
          r_idx   <= '0;
          r_acc   <= '0;
        end
      end else begin
        r_a     <= r_a >> SLICE;
        r_b     <= r_b >> SLICE;
        r_carry <= w_sc;
        r_acc   <= w_acc_next;
        if (w_last) begin
          // Only the completed word is published; s never shows partials.
          r_idx   <= '0;
          r_s     <= w_acc_next;
          r_c_out <= w_sc;
          r_v     <= w_smsb ^ w_sc;
          r_done  <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = r_done;
  assign s     = r_s;
  assign c_out = r_c_out;
  assign v     = r_v;

endmodule
